// File: rtl/dac_spi_driver.sv
// dac_spi_driver
// Serializes one 12-bit sample pair per handshake onto a dual-data-line SPI
// DAC (DAC121S101-style, Pmod DA2 pinout). Both channels share SCLK/SYNC and
// shift a 16-bit frame {2'b00, pd_mode, code} MSB first, in lockstep.
//
// Ports:
//   clk, rst_n            system clock, synchronous active-low reset
//   sample_a, sample_b    12-bit codes for channel A / B
//   pd_mode               DAC power-down field (00 = normal operation)
//   sample_valid/ready    upstream handshake (see below)
//   dac_sync_n            frame select, active low
//   dac_sclk              serial clock, idles high
//   dac_din_a, dac_din_b  serial data lines
//   busy                  frame or inter-frame gap in progress
//   frame_done            one-cycle pulse as SYNC returns high after bit 0
//   state_dbg             current FSM state (IDLE=0, SHIFT=1, GAP=2)
//
// Handshake: a sample is taken on every rising clk edge where sample_valid
// and sample_ready are both high. sample_ready is high only in IDLE and does
// not depend on sample_valid. There is no buffering: valid while not ready is
// ignored, and data captured on accept is immune to later input changes.
module dac_spi_driver #(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] sample_a,
  input  logic [11:0] sample_b,
  input  logic [1:0]  pd_mode,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        dac_sync_n,
  output logic        dac_sclk,
  output logic        dac_din_a,
  output logic        dac_din_b,
  output logic        busy,
  output logic        frame_done,
  output logic [1:0]  state_dbg
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [15:0]      sh_a_q, sh_a_d;
  logic [15:0]      sh_b_q, sh_b_d;
  logic             sync_n_q, sync_n_d;
  logic             sclk_q, sclk_d;
  logic             din_a_q, din_a_d;
  logic             din_b_q, din_b_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic [15:0]      word_a, word_b;

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    sh_a_d       = sh_a_q;
    sh_b_d       = sh_b_q;
    sync_n_d     = sync_n_q;
    sclk_d       = sclk_q;
    din_a_d      = din_a_q;
    din_b_d      = din_b_q;
    frame_done_d = 1'b0;
    word_a       = {2'b00, pd_mode, sample_a};
    word_b       = {2'b00, pd_mode, sample_b};

    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          // Bit 15 goes out on the accept edge itself; the shifters keep
          // the remaining 15 bits left-aligned so [15] is always next.
          state_d   = SHIFT;
          sync_n_d  = 1'b0;
          sclk_d    = 1'b1;
          din_a_d   = word_a[15];
          din_b_d   = word_b[15];
          sh_a_d    = {word_a[14:0], 1'b0};
          sh_b_d    = {word_b[14:0], 1'b0};
          div_cnt_d = '0;
          bit_cnt_d = 4'd15;
        end
      end

      SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (sclk_q) begin
            // End of high phase: falling edge, DAC samples din here.
            sclk_d = 1'b0;
          end else if (bit_cnt_q == 4'd0) begin
            // Bit 0 low phase over: close the frame. The decrement wraps
            // the bit counter back to 15 only on this exit.
            state_d      = GAP;
            sync_n_d     = 1'b1;
            sclk_d       = 1'b1;
            din_a_d      = 1'b0;
            din_b_d      = 1'b0;
            frame_done_d = 1'b1;
            bit_cnt_d    = bit_cnt_q - 4'd1;
            gap_cnt_d    = '0;
          end else begin
            // Start of the next bit's high phase: the only point din moves.
            bit_cnt_d = bit_cnt_q - 4'd1;
            sclk_d    = 1'b1;
            din_a_d   = sh_a_q[15];
            din_b_d   = sh_b_q[15];
            sh_a_d    = {sh_a_q[14:0], 1'b0};
            sh_b_d    = {sh_b_q[14:0], 1'b0};
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      sh_a_q       <= '0;
      sh_b_q       <= '0;
      sync_n_q     <= 1'b1;
      sclk_q       <= 1'b1;
      din_a_q      <= 1'b0;
      din_b_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      sh_a_q       <= sh_a_d;
      sh_b_q       <= sh_b_d;
      sync_n_q     <= sync_n_d;
      sclk_q       <= sclk_d;
      din_a_q      <= din_a_d;
      din_b_q      <= din_b_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sample_ready = (state_q == IDLE);
  assign dac_sync_n   = sync_n_q;
  assign dac_sclk     = sclk_q;
  assign dac_din_a    = din_a_q;
  assign dac_din_b    = din_b_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign state_dbg    = state_q;

endmodule
